digimax_player: RTL and testbench
=================================

DIGIMAX_PLAYER -- requirements
Module: digimax_player

Interface
REQ-001 Parameter FIFO_DEPTH, default 16 (power of two, >=4), sample FIFO entries.
REQ-002 Parameter DIV_W, default 16, rate-divider width.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_wr  in  1  one-cycle CPU write strobe.
REQ-006 cpu_addr  in  16  CPU write address.
REQ-007 cpu_data  in  8  CPU write data.
REQ-008 out_wr_n  out  1  active-low DAC write strobe, one cycle per write.
REQ-009 out_addr  out  16  DAC register address, $DE00-$DE03.
REQ-010 out_data  out  8  DAC sample value.
REQ-011 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 irq  out  1  level request for a FIFO refill.
REQ-013 underrun, overflow, late  out  1 each  sticky status flags.

Function
REQ-014 Register map: $DE04 FIFO push; $DE05 divider[7:0]; $DE06 divider[DIV_W-1:8]; $DE07 control: bit0 enable, bits2:1 channel count minus 1, bit3 irq enable, bit4 flush (self-clearing).
REQ-015 CPU write to $DE00-$DE03: pass through to the output next cycle (out_wr_n=0, same addr/data); this is the direct path.
REQ-016 Output arbitration: the direct path has priority; at most one output write per cycle; out_wr_n is registered and low for exactly one cycle per write.
REQ-017 States: IDLE (enable=0), RUN (enable=1, no write pending), PEND (playback write deferred).
REQ-018 Timer: the enabling control write loads the counter with the divider; in RUN/PEND it decrements each cycle; at 0 it produces a tick and reloads.
REQ-019 Tick rate: first tick divider+1 cycles after the enabling write, then one every divider+1 cycles; divider 0 gives a tick every cycle.
REQ-020 Tick in RUN with FIFO non-empty: pop one sample and write it to $DE00+chan in the next cycle; chan increments and wraps after channel count.
REQ-021 Tick with FIFO empty: no pop, no write, chan unchanged, underrun set.
REQ-022 Tick coincident with a direct write: go to PEND; the playback write issues in the first cycle with no direct write, then return to RUN.
REQ-023 Tick while in PEND: that tick is dropped (no pop) and late is set.
REQ-024 Push to a full FIFO: data dropped, overflow set; push and pop in the same cycle when full: both accepted, count unchanged.
REQ-025 Push and tick in the same cycle when empty: push accepted, no pop, underrun set.
REQ-026 Flush: pointers and count go to 0 next cycle; a push in the same cycle is discarded; any pending playback write is cancelled (PEND->RUN).
REQ-027 Disable (enable 1->0): go to IDLE immediately; cancel pending write; chan=0; timer stops; FIFO contents retained.
REQ-028 Any write to $DE07 clears underrun, overflow and late.
REQ-029 irq = irq_enable AND enable AND fifo_count <= FIFO_DEPTH/2.
REQ-030 Divider writes while running take effect at the next reload.

Reset
REQ-031 On reset: state IDLE, out_wr_n=1, out_addr=$DE00, out_data=0, FIFO empty, fifo_count=0, divider=0, control=0, chan=0, irq=0, all sticky flags 0.
REQ-032 Reset asserted mid-playback aborts any pending write with no output strobe.

Structure
REQ-033 Register addresses, control bit positions and state encodings go in shared package digimax_pkg.
REQ-034 The FIFO is sub-module digimax_fifo (sync, one push port, one pop port, count, full, empty).

Verification
REQ-035 divider=3, channel count 4, FIFO holds 10,20,30,40, enable -> writes $DE00=10, $DE01=20, $DE02=30, $DE03=40, spaced 4 cycles apart.
REQ-036 Direct write $DE01=$55 in the same cycle as a tick -> $DE01=$55 at T+1, playback write at T+2, late stays 0.
REQ-037 Enable with an empty FIFO, divider=0 -> no out_wr_n pulses, underrun=1; a write to $DE07 clears it.
REQ-038 17 pushes with FIFO_DEPTH=16 -> fifo_count=16, overflow=1, first 16 values played in order.
REQ-039 irq enabled, 9 samples, divider=0 -> irq rises once fifo_count reaches 8; flush -> fifo_count=0 next cycle.
REQ-040 Reset during PEND -> no output strobe, all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/digimax_pkg.sv
// Shared definitions for the DigiMax sample player: register map, control
// bit positions, playback states and small decode helpers.
package digimax_pkg;

  localparam logic [15:0] ADDR_DAC0   = 16'hDE00;
  localparam logic [15:0] ADDR_DAC3   = 16'hDE03;
  localparam logic [15:0] ADDR_PUSH   = 16'hDE04;
  localparam logic [15:0] ADDR_DIV_LO = 16'hDE05;
  localparam logic [15:0] ADDR_DIV_HI = 16'hDE06;
  localparam logic [15:0] ADDR_CTRL   = 16'hDE07;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_NCH_LSB  = 1;
  localparam int CTRL_NCH_MSB  = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_FLUSH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  function automatic logic is_dac_addr(input logic [15:0] addr);
    return (addr >= ADDR_DAC0) && (addr <= ADDR_DAC3);
  endfunction

  // Channel index after a playback write; wraps once the last channel is used.
  function automatic logic [1:0] next_chan(input logic [1:0] chan, input logic [1:0] last);
    return (chan >= last) ? 2'd0 : chan + 2'd1;
  endfunction

endpackage

// File: rtl/digimax_fifo.sv
// Synchronous sample FIFO with one push port, one pop port, occupancy count
// and a flush that empties it on the next edge.
module digimax_fifo
  import digimax_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Accept/reject decisions and next pointer/count values
  always_comb begin
    pop_ok_s  = pop_i && !empty_o && !flush_i;
    // A full FIFO still takes a push when a pop frees the head slot this cycle.
    push_ok_s = push_i && (!full_o || pop_ok_s) && !flush_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
      rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/digimax_player.sv
// DigiMax sample player: CPU register file, rate timer and playback FSM that
// streams FIFO samples to the $DE00-$DE03 DAC registers beside a direct path.
module digimax_player
  import digimax_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_wr,
  input  logic [15:0]                   cpu_addr,
  input  logic [7:0]                    cpu_data,
  output logic                          out_wr_n,
  output logic [15:0]                   out_addr,
  output logic [7:0]                    out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          irq,
  output logic                          underrun,
  output logic                          overflow,
  output logic                          late
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic             en_q, en_d, irq_en_q, irq_en_d;
  logic [1:0]       nch_q, nch_d, chan_q, chan_d, pend_chan_q, pend_chan_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             out_wr_n_q, out_wr_n_d;
  logic [15:0]      out_addr_q, out_addr_d;
  logic [7:0]       out_data_q, out_data_d, out_data_s;
  logic             underrun_q, underrun_d, overflow_q, overflow_d, late_q, late_d;

  logic             dw_s, cw_s, push_s, flush_s, dis_s, ena_s;
  logic             tick_s, act_s, pop_s, play_s;
  logic [1:0]       play_chan_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [7:0]       fifo_rdata_s;

  digimax_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (cpu_data),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Decode this cycle's CPU write and whether the rate timer ticks
  always_comb begin
    dw_s    = cpu_wr && is_dac_addr(cpu_addr);
    cw_s    = cpu_wr && (cpu_addr == ADDR_CTRL);
    push_s  = cpu_wr && (cpu_addr == ADDR_PUSH);
    flush_s = cw_s && cpu_data[CTRL_FLUSH];
    dis_s   = cw_s && !cpu_data[CTRL_EN];
    ena_s   = cw_s && cpu_data[CTRL_EN];
    tick_s  = (state_q != ST_IDLE) && (cnt_q == {DIV_W{1'b0}});
    // A disabling or flushing control write overrides the tick's playback action.
    act_s   = tick_s && !dis_s && !flush_s;
    pop_s   = act_s && (state_q == ST_RUN) && !fifo_empty_s;
  end

  // Register file, timer, playback FSM, output arbitration and status flags
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    nch_d       = nch_q;
    irq_en_d    = irq_en_q;
    chan_d      = chan_q;
    pend_chan_d = pend_chan_q;
    pend_data_d = pend_data_q;
    play_s      = 1'b0;
    play_chan_s = chan_q;
    out_data_s  = fifo_rdata_s;
    out_wr_n_d  = 1'b1;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    if (cpu_wr) begin
      case (cpu_addr)
        ADDR_DIV_LO: div_d[7:0]       = cpu_data;
        ADDR_DIV_HI: div_d[DIV_W-1:8] = (DIV_W-8)'(cpu_data);
        ADDR_CTRL: begin
          en_d     = cpu_data[CTRL_EN];
          nch_d    = cpu_data[CTRL_NCH_MSB:CTRL_NCH_LSB];
          irq_en_d = cpu_data[CTRL_IRQ_EN];
        end
        default: div_d = div_q;
      endcase
    end else begin
      div_d = div_q;
    end

    if (state_q == ST_IDLE) begin
      cnt_d = ena_s ? div_q : cnt_q;
    end else if (dis_s) begin
      cnt_d = cnt_q;
    end else if (tick_s) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - DIV_W'(1'b1);
    end

    case (state_q)
      ST_IDLE: begin
        chan_d  = 2'd0;
        state_d = ena_s ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (dis_s) begin
          state_d = ST_IDLE;
          chan_d  = 2'd0;
        end else if (pop_s) begin
          chan_d = next_chan(chan_q, nch_q);
          if (dw_s) begin
            state_d     = ST_PEND;
            pend_chan_d = chan_q;
            pend_data_d = fifo_rdata_s;
          end else begin
            play_s      = 1'b1;
            play_chan_s = chan_q;
            out_data_s  = fifo_rdata_s;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PEND: begin
        if (dis_s) begin
          state_d = ST_IDLE;
          chan_d  = 2'd0;
        end else if (flush_s) begin
          state_d = ST_RUN;
        end else if (!dw_s) begin
          state_d     = ST_RUN;
          play_s      = 1'b1;
          play_chan_s = pend_chan_q;
          out_data_s  = pend_data_q;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        chan_d  = 2'd0;
      end
    endcase

    if (dw_s) begin
      out_wr_n_d = 1'b0;
      out_addr_d = cpu_addr;
      out_data_d = cpu_data;
    end else if (play_s) begin
      out_wr_n_d = 1'b0;
      out_addr_d = ADDR_DAC0 + {14'd0, play_chan_s};
      out_data_d = out_data_s;
    end else begin
      out_wr_n_d = 1'b1;
    end

    // A new event in the same cycle as a control write still sets its flag.
    underrun_d = (underrun_q && !cw_s) || (act_s && (state_q == ST_RUN) && fifo_empty_s);
    late_d     = (late_q && !cw_s) || (act_s && (state_q == ST_PEND));
    overflow_d = (overflow_q && !cw_s) || (push_s && fifo_full_s && !pop_s);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= {DIV_W{1'b0}};
      cnt_q       <= {DIV_W{1'b0}};
      en_q        <= 1'b0;
      nch_q       <= 2'd0;
      irq_en_q    <= 1'b0;
      chan_q      <= 2'd0;
      pend_chan_q <= 2'd0;
      pend_data_q <= 8'd0;
      out_wr_n_q  <= 1'b1;
      out_addr_q  <= ADDR_DAC0;
      out_data_q  <= 8'd0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      nch_q       <= nch_d;
      irq_en_q    <= irq_en_d;
      chan_q      <= chan_d;
      pend_chan_q <= pend_chan_d;
      pend_data_q <= pend_data_d;
      out_wr_n_q  <= out_wr_n_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      late_q      <= late_d;
    end
  end

  assign out_wr_n = out_wr_n_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign underrun = underrun_q;
  assign overflow = overflow_q;
  assign late     = late_q;
  assign irq      = irq_en_q && en_q && (fifo_count <= CW'(FIFO_DEPTH / 2));

endmodule

// File: tb/tb_digimax_player.sv
// Bench for digimax_player: directed scenarios with hand-computed results plus
// a random run, all cross-checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_digimax_player;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        out_wr_n;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  logic [4:0]  fifo_count;
  logic        irq, underrun, overflow, late;

  digimax_player #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .out_wr_n(out_wr_n), .out_addr(out_addr), .out_data(out_data), .fifo_count(fifo_count),
    .irq(irq), .underrun(underrun), .overflow(overflow), .late(late)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int g = 0;
  bit chk_en = 1'b0;

  // Model: playback timing is tracked as the absolute cycle of the next tick.
  logic        m_en, m_irqen, m_pend, m_und, m_ovf, m_late;
  logic [1:0]  m_nch, m_chan, m_pa;
  logic [7:0]  m_pd;
  logic [15:0] m_div;
  logic [7:0]  q[$];
  int          m_cyc = 0;
  int          m_next = 0;
  logic        e_wr_n, e_irq;
  logic [15:0] e_addr;
  logic [7:0]  e_data;
  int          e_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, g);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    logic dw, cw, push, tick, cancel, was_pend, play, und_e, late_e, ovf_e;
    logic [1:0] pa;
    logic [7:0] pd, s;
    pa = 2'd0; pd = 8'h00;
    if (r) begin
      m_en = 1'b0; m_irqen = 1'b0; m_nch = 2'd0; m_div = 16'h0000; q.delete();
      m_chan = 2'd0; m_pend = 1'b0; m_und = 1'b0; m_ovf = 1'b0; m_late = 1'b0;
      e_wr_n = 1'b1; e_addr = 16'hDE00; e_data = 8'h00;
    end else begin
      dw = w && (a >= 16'hDE00) && (a <= 16'hDE03);
      cw = w && (a == 16'hDE07);
      push = w && (a == 16'hDE04);
      tick = m_en && (m_cyc == m_next);
      if (tick) m_next = m_cyc + int'(m_div) + 1;
      cancel = cw && (!d[0] || d[4]);
      was_pend = m_pend;
      play = 1'b0; und_e = 1'b0; late_e = 1'b0; ovf_e = 1'b0;
      if (was_pend && !dw && !cancel) begin
        play = 1'b1; pa = m_pa; pd = m_pd; m_pend = 1'b0;
      end
      if (tick && !cancel) begin
        if (was_pend) late_e = 1'b1;
        else if (q.size() == 0) und_e = 1'b1;
        else begin
          s = q.pop_front();
          if (dw) begin m_pend = 1'b1; m_pa = m_chan; m_pd = s; end
          else begin play = 1'b1; pa = m_chan; pd = s; end
          m_chan = (m_chan >= m_nch) ? 2'd0 : m_chan + 2'd1;
        end
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_e = 1'b1;
      end
      if (cw) begin
        if (!m_en && d[0]) m_next = m_cyc + int'(m_div) + 1;
        if (!d[0]) begin m_chan = 2'd0; m_pend = 1'b0; end
        if (d[4]) begin q.delete(); m_pend = 1'b0; end
        m_en = d[0]; m_nch = d[2:1]; m_irqen = d[3];
        m_und = 1'b0; m_ovf = 1'b0; m_late = 1'b0;
      end
      m_und = m_und | und_e;
      m_ovf = m_ovf | ovf_e;
      m_late = m_late | late_e;
      if (w && a == 16'hDE05) m_div[7:0] = d;
      if (w && a == 16'hDE06) m_div[15:8] = d;
      if (dw) begin e_wr_n = 1'b0; e_addr = a; e_data = d; end
      else if (play) begin e_wr_n = 1'b0; e_addr = 16'hDE00 + {14'd0, pa}; e_data = pd; end
      else e_wr_n = 1'b1;
    end
    m_cyc++;
    e_count = q.size();
    e_irq = m_irqen && m_en && (q.size() <= DEPTH / 2);
  endtask

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_wr_n", out_wr_n, e_wr_n);
      chk("out_addr", out_addr, e_addr);
      chk("out_data", out_data, e_data);
      chk("fifo_count", fifo_count, e_count);
      chk("irq", irq, e_irq);
      chk("underrun", underrun, m_und);
      chk("overflow", overflow, m_ovf);
      chk("late", late, m_late);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    #1;
    reset = r; cpu_wr = w; cpu_addr = a; cpu_data = d;
    model_step(r, w, a, d);
    g++;
    chk_en = 1'b1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, a, d);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wait_write(input int maxc, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < maxc; i++) begin
      idle();
      if (out_wr_n === 1'b0) begin ok = 1'b1; at = g; break; end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, at, prev, np;
    bit ok;
    logic [7:0] got_d[$];
    logic [15:0] got_a[$];

    // Reset values
    do_reset();
    idle();
    chk("rst_wr_n", out_wr_n, 1'b1);
    chk("rst_addr", out_addr, 16'hDE00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_flags", {underrun, overflow, late}, 3'b000);

    // Four channels, divider 3: four writes 4 cycles apart
    do_reset();
    wr(16'hDE04, 8'd10); wr(16'hDE04, 8'd20); wr(16'hDE04, 8'd30); wr(16'hDE04, 8'd40);
    wr(16'hDE05, 8'd3); wr(16'hDE07, 8'h07);
    e = g; prev = g;
    for (int k = 0; k < 4; k++) begin
      wait_write(12, at, ok);
      chk("seq_seen", ok, 1'b1);
      chk("seq_addr", out_addr, 16'hDE00 + 16'(k));
      chk("seq_data", out_data, 8'(10 * (k + 1)));
      if (k == 0) chk("seq_first", at - e, 5);
      else chk("seq_gap", at - prev, 4);
      prev = at;
    end

    // Direct write colliding with a tick defers the playback write
    do_reset();
    wr(16'hDE04, 8'h77); wr(16'hDE05, 8'd9); wr(16'hDE07, 8'h07);
    for (int i = 0; i < 9; i++) idle();
    wr(16'hDE01, 8'h55);
    idle();
    chk("col_direct", {out_wr_n, out_addr, out_data}, {1'b0, 16'hDE01, 8'h55});
    idle();
    chk("col_play", {out_wr_n, out_addr, out_data}, {1'b0, 16'hDE00, 8'h77});
    chk("col_late", late, 1'b0);
    idle();
    chk("col_done", out_wr_n, 1'b1);

    // Empty FIFO at divider 0: only underrun, cleared by a control write
    do_reset();
    wr(16'hDE07, 8'h01);
    np = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (out_wr_n === 1'b0) np++;
    end
    chk("und_pulses", np, 0);
    chk("und_set", underrun, 1'b1);
    wr(16'hDE07, 8'h00);
    idle();
    chk("und_clear", underrun, 1'b0);

    // 17 pushes into 16 entries: overflow, first 16 values play in order
    do_reset();
    for (int i = 1; i <= 17; i++) wr(16'hDE04, 8'(i));
    idle();
    chk("ovf_count", fifo_count, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    wr(16'hDE07, 8'h07);
    for (int i = 0; i < 30; i++) begin
      idle();
      if (out_wr_n === 1'b0) begin got_d.push_back(out_data); got_a.push_back(out_addr); end
    end
    chk("ovf_nplay", got_d.size(), 16);
    for (int i = 0; i < got_d.size(); i++) begin
      chk("ovf_pdata", got_d[i], 8'(i + 1));
      chk("ovf_paddr", got_a[i], 16'hDE00 + 16'(i % 4));
    end

    // irq at half full, then flush
    do_reset();
    for (int i = 0; i < 9; i++) wr(16'hDE04, 8'(i + 100));
    wr(16'hDE07, 8'h09);
    idle();
    chk("irq_cnt9", fifo_count, 5'd9);
    chk("irq_low", irq, 1'b0);
    idle();
    chk("irq_cnt8", fifo_count, 5'd8);
    chk("irq_high", irq, 1'b1);
    wr(16'hDE07, 8'h19);
    idle();
    chk("flush_cnt", fifo_count, 5'd0);

    // Reset while a playback write is pending
    do_reset();
    wr(16'hDE04, 8'h05); wr(16'hDE05, 8'd5); wr(16'hDE07, 8'h01);
    for (int i = 0; i < 5; i++) idle();
    wr(16'hDE02, 8'h33);
    do_reset();
    chk("prst_direct", {out_wr_n, out_addr}, {1'b0, 16'hDE02});
    idle();
    chk("prst_vals", {out_wr_n, out_addr, out_data, fifo_count}, {1'b1, 16'hDE00, 8'h00, 5'd0});
    chk("prst_flags", {irq, underrun, overflow, late}, 4'b0000);
    idle();
    chk("prst_nostrobe", out_wr_n, 1'b1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r, k;
      logic [7:0] ctl;
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else if (r < 100) idle();
      else begin
        k = $urandom_range(0, 19);
        if (k < 4) wr(16'hDE00 + 16'(k), 8'($urandom_range(0, 255)));
        else if (k < 11) wr(16'hDE04, 8'($urandom_range(0, 255)));
        else if (k == 11) wr(16'hDE05, 8'($urandom_range(0, 4)));
        else if (k == 12) wr(16'hDE06, 8'h00);
        else if (k < 16) begin
          ctl = {3'b000, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0)};
          wr(16'hDE07, ctl);
        end
        else wr(16'(16'hDE08 + 16'($urandom_range(0, 7))), 8'($urandom_range(0, 255)));
      end
    end
    for (int i = 0; i < 20; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
